fs_dither_stream: RTL and testbench

//  Streaming Floyd-Steinberg error-diffusion engine. Takes one raster-order greyscale frame as a pixel stream and quantizes each pixel to 2^Q_BITS levels.

---
 rtl/fs_dither_stream_pkg.sv | 28 ++
 rtl/fs_dither_stream_if.sv | 27 ++
 rtl/fs_dither_stream_quantizer.sv | 46 ++++
 rtl/fs_dither_stream.sv | 126 ++++++++++++
 tb/tb_fs_dither_stream.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fs_dither_stream_pkg.sv
// Shared types, Floyd-Steinberg weights and the level reconstruction helper
// for the streaming dither engine.
package dither_pkg;

  typedef enum logic [1:0] {DS_IDLE, DS_RUN, DS_DRAIN} dither_state_t;

  localparam int W_E  = 7;
  localparam int W_SW = 3;
  localparam int W_S  = 5;
  localparam int W_SE = 1;

  // Replicates a q_bits-wide level code across pix_w bits (MSB-aligned), so
  // code 0 maps to 0 and the top code maps to full scale.
  function automatic logic [31:0] recon(input logic [31:0] code, input int q_bits,
                                        input int pix_w);
    logic [31:0] r;
    int t;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < pix_w) begin
        t = pix_w - 1 - i;
        r[5'(i)] = code[5'(q_bits - 1 - (t % q_bits))];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fs_dither_stream_if.sv
// Pixel-in / level-out stream pair of the dither engine. master is the
// upstream/downstream side, slave is the engine.
interface fs_dither_stream_if #(
  parameter int PIX_W  = 8,
  parameter int Q_BITS = 1
);
  logic              in_valid;
  logic              in_ready;
  logic              in_sof;
  logic [PIX_W-1:0]  in_pixel;
  logic              out_valid;
  logic              out_ready;
  logic [PIX_W-1:0]  out_pixel;
  logic [Q_BITS-1:0] out_code;
  logic              out_eol;
  logic              out_eof;

  modport master (
    output in_valid, in_sof, in_pixel, out_ready,
    input  in_ready, out_valid, out_pixel, out_code, out_eol, out_eof
  );

  modport slave (
    input  in_valid, in_sof, in_pixel, out_ready,
    output in_ready, out_valid, out_pixel, out_code, out_eol, out_eof
  );
endinterface

// File: rtl/fs_dither_stream_quantizer.sv
// Combinational quantizer: picks the nearest reconstruction level to v
// (ties to the higher code) and returns the signed residual error.
module fs_quantizer
  import dither_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int Q_BITS = 1,
  parameter int ACC_W  = PIX_W + 6
) (
  input  logic [PIX_W-1:0]        v,
  input  logic                    dither_en,
  output logic [Q_BITS-1:0]       code,
  output logic [PIX_W-1:0]        level,
  output logic signed [ACC_W-1:0] err
);
  localparam int LMAX = (1 << Q_BITS) - 1;

  int k, x, rc, dd, bd, best, best_lv;

  // Only the truncated level and its two neighbours can be nearest.
  always_comb begin
    k       = int'(v >> (PIX_W - Q_BITS));
    x       = 0;
    rc      = 0;
    dd      = 0;
    bd      = 1 << (PIX_W + 1);
    best    = 0;
    best_lv = 0;
    for (int j = -1; j <= 1; j++) begin
      x = k + j;
      if (x >= 0 && x <= LMAX) begin
        rc = int'(recon(32'(x), Q_BITS, PIX_W));
        dd = (int'(v) > rc) ? int'(v) - rc : rc - int'(v);
        if (dd <= bd) begin
          bd      = dd;
          best    = x;
          best_lv = rc;
        end
      end
    end
    code  = Q_BITS'(best);
    level = PIX_W'(best_lv);
    err   = dither_en ? ACC_W'(int'(v) - best_lv) : '0;
  end

endmodule

// File: rtl/fs_dither_stream.sv
// Streaming Floyd-Steinberg error-diffusion engine: one raster pixel per
// clock, register line buffer of next-row error, single output register.
module fs_dither_stream
  import dither_pkg::*;
#(
  parameter int IMAGEX = 16,
  parameter int IMAGEY = 16,
  parameter int PIX_W  = 8,
  parameter int Q_BITS = 1,
  parameter int ACC_W  = PIX_W + 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dither_en,
  fs_dither_stream_if.slave st,
  output logic          busy,
  output logic          frame_done,
  output logic          sof_err
);
  localparam int CW = $clog2(IMAGEX);
  localparam int RW = $clog2(IMAGEY);

  dither_state_t            state;
  logic [CW-1:0]            col, pc;
  logic [RW-1:0]            row, pr;
  logic signed [ACC_W-1:0]  lb [IMAGEX];
  logic signed [ACC_W-1:0]  e_east, s0, s1, acc, s0b, s1b, ns0, ns1, err;
  logic signed [ACC_W:0]    acc_r, rnd;
  logic signed [ACC_W+1:0]  pix_x, rnd_x, sum;
  logic [PIX_W-1:0]         v, level;
  logic [Q_BITS-1:0]        code;
  logic                     fire_in, fire_out, take, fresh, last_col, last_row;
  logic                     res_valid, res_eol, res_eof;
  logic [PIX_W-1:0]         res_pixel;
  logic [Q_BITS-1:0]        res_code;

  assign st.in_ready  = !res_valid || st.out_ready;
  assign st.out_valid = res_valid;
  assign st.out_pixel = res_pixel;
  assign st.out_code  = res_code;
  assign st.out_eol   = res_eol;
  assign st.out_eof   = res_eof;
  assign busy         = (state != DS_IDLE);

  assign fire_in  = st.in_valid && st.in_ready;
  assign fire_out = res_valid && st.out_ready;
  // An sof pixel always restarts at (0,0); outside RUN only sof pixels are kept.
  assign fresh    = st.in_sof;
  assign take     = fire_in && (state == DS_RUN || fresh);
  assign pc       = fresh ? '0 : col;
  assign pr       = fresh ? '0 : row;
  assign last_col = (pc == CW'(IMAGEX - 1));
  assign last_row = (pr == RW'(IMAGEY - 1));

  assign acc   = fresh ? '0 : e_east + lb[pc];
  assign acc_r = {acc[ACC_W-1], acc} + 'sd8;
  assign rnd   = acc_r >>> 4;
  assign pix_x = {{(ACC_W + 2 - PIX_W){1'b0}}, st.in_pixel};
  assign rnd_x = {rnd[ACC_W], rnd};
  assign sum   = pix_x + rnd_x;
  assign v     = sum[ACC_W+1] ? '0 : (|sum[ACC_W:PIX_W]) ? '1 : sum[PIX_W-1:0];

  fs_quantizer #(.PIX_W(PIX_W), .Q_BITS(Q_BITS), .ACC_W(ACC_W)) u_quant (
    .v         (v),
    .dither_en (dither_en),
    .code      (code),
    .level     (level),
    .err       (err)
  );

  // s0/s1 track next-row error for columns c-1 and c; the SE term seeds s1.
  assign s0b = fresh ? '0 : s0;
  assign s1b = fresh ? '0 : s1;
  assign ns0 = s0b + ((pc != '0) ? ACC_W'(err * W_SW) : '0);
  assign ns1 = s1b + ACC_W'(err * W_S);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DS_IDLE;
      col        <= '0;
      row        <= '0;
      e_east     <= '0;
      s0         <= '0;
      s1         <= '0;
      for (int i = 0; i < IMAGEX; i++) lb[i] <= '0;
      res_valid  <= 1'b0;
      res_pixel  <= '0;
      res_code   <= '0;
      res_eol    <= 1'b0;
      res_eof    <= 1'b0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      frame_done <= (state == DS_DRAIN) && fire_out;
      sof_err    <= fire_in && fresh && (state == DS_RUN) && (col != '0 || row != '0);
      if (fire_out) res_valid <= 1'b0;
      if (take) begin
        res_valid <= 1'b1;
        res_pixel <= level;
        res_code  <= code;
        res_eol   <= last_col;
        res_eof   <= last_col && last_row;
        col       <= last_col ? '0 : pc + 1'b1;
        row       <= last_col ? (last_row ? '0 : pr + 1'b1) : pr;
        state     <= (last_col && last_row) ? DS_DRAIN : DS_RUN;
        e_east    <= last_col ? '0 : ACC_W'(err * W_E);
        if (fresh) for (int i = 0; i < IMAGEX; i++) lb[i] <= '0;
        if (!last_row) begin
          if (pc != '0) lb[pc - 1'b1] <= ns0;
          if (last_col) lb[pc] <= ns1;
        end
        if (last_col) begin
          s0 <= '0;
          s1 <= '0;
        end else begin
          s0 <= ns1;
          s1 <= ACC_W'(err * W_SE);
        end
        if (last_col && last_row) for (int i = 0; i < IMAGEX; i++) lb[i] <= '0;
      end else if (state == DS_DRAIN && fire_out) begin
        state <= DS_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_fs_dither_stream.sv
// Bench for fs_dither_stream: two engines (Q_BITS=1 and 2) on one stimulus,
// checked against a whole-frame Floyd-Steinberg model.
module tb_fs_dither_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       dither_en = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_pixel = 8'h00;
  logic       busy1, busy2, fd1, fd2, se1, se2;

  always #5 clk = ~clk;

  fs_dither_stream_if #(.PIX_W(8), .Q_BITS(1)) if1 ();
  fs_dither_stream_if #(.PIX_W(8), .Q_BITS(2)) if2 ();

  assign if1.in_valid  = in_valid;
  assign if1.in_sof    = in_sof;
  assign if1.in_pixel  = in_pixel;
  assign if1.out_ready = out_ready;
  assign if2.in_valid  = in_valid;
  assign if2.in_sof    = in_sof;
  assign if2.in_pixel  = in_pixel;
  assign if2.out_ready = out_ready;

  fs_dither_stream #(.IMAGEX(16), .IMAGEY(16), .PIX_W(8), .Q_BITS(1), .ACC_W(14)) dut1 (
    .clk(clk), .rst_n(rst_n), .dither_en(dither_en), .st(if1),
    .busy(busy1), .frame_done(fd1), .sof_err(se1));

  fs_dither_stream #(.IMAGEX(16), .IMAGEY(16), .PIX_W(8), .Q_BITS(2), .ACC_W(14)) dut2 (
    .clk(clk), .rst_n(rst_n), .dither_en(dither_en), .st(if2),
    .busy(busy2), .frame_done(fd2), .sof_err(se2));

  typedef struct packed {
    logic [7:0] pix;
    logic [7:0] code;
    logic       eol;
    logic       eof;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   img [256];
  int   errors = 0;
  int   checks = 0;
  int   fd_cnt1 = 0, fd_cnt2 = 0, se_cnt1 = 0, se_cnt2 = 0;
  bit   bp = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Whole-frame error diffusion on a 2-D array of 1/16-unit error sums.
  task automatic push_model(input int d, input int q, input bit en, input int npix);
    int e [0:16][0:17];
    int r, c, acc, v, lv, rc, dd, bd, best, er;
    exp_t x;
    for (int i = 0; i <= 16; i++)
      for (int j = 0; j <= 17; j++) e[i][j] = 0;
    lv = (1 << q) - 1;
    for (int i = 0; i < npix; i++) begin
      r   = i / 16;
      c   = i % 16;
      acc = e[r][c+1];
      v   = img[i] + ((acc + 8) >>> 4);
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      bd = 1000;
      best = 0;
      for (int k = 0; k <= lv; k++) begin
        rc = k * 255 / lv;
        dd = (v > rc) ? v - rc : rc - v;
        if (dd <= bd) begin
          bd = dd;
          best = k;
        end
      end
      er = en ? v - best * 255 / lv : 0;
      if (c < 15) e[r][c+2] += 7 * er;
      e[r+1][c]   += 3 * er;
      e[r+1][c+1] += 5 * er;
      e[r+1][c+2] += er;
      x.pix  = 8'(best * 255 / lv);
      x.code = 8'(best);
      x.eol  = (c == 15);
      x.eof  = (c == 15) && (r == 15);
      if (d == 1) q1.push_back(x);
      else q2.push_back(x);
    end
  endtask

  task automatic cmp_out(input int d, input logic rdy, input logic [7:0] pix,
                         input logic [7:0] code, input logic eol, input logic eof);
    exp_t e;
    if ((d == 1) ? (q1.size() == 0) : (q2.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL out%0d_unexpected: got pixel %0d, expected no output", d, pix);
      return;
    end
    e = (d == 1) ? q1[0] : q2[0];
    check((d == 1) ? "out1_pixel" : "out2_pixel", int'(pix), int'(e.pix));
    check((d == 1) ? "out1_code"  : "out2_code",  int'(code), int'(e.code));
    check((d == 1) ? "out1_eol"   : "out2_eol",   int'(eol), int'(e.eol));
    check((d == 1) ? "out1_eof"   : "out2_eof",   int'(eof), int'(e.eof));
    if (rdy) begin
      if (d == 1) void'(q1.pop_front());
      else void'(q2.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_state1", int'({if1.out_valid, if1.out_eol, if1.out_eof, busy1, fd1, se1,
                                |if1.out_pixel, |if1.out_code}), 0);
      check("rst_state2", int'({if2.out_valid, if2.out_eol, if2.out_eof, busy2, fd2, se2,
                                |if2.out_pixel, |if2.out_code}), 0);
      check("rst_in_ready", int'({if1.in_ready, if2.in_ready}), 3);
    end else begin
      if (fd1) fd_cnt1++;
      if (fd2) fd_cnt2++;
      if (se1) se_cnt1++;
      if (se2) se_cnt2++;
      if (if1.out_valid)
        cmp_out(1, if1.out_ready, if1.out_pixel, 8'(if1.out_code), if1.out_eol, if1.out_eof);
      if (if2.out_valid)
        cmp_out(2, if2.out_ready, if2.out_pixel, 8'(if2.out_code), if2.out_eol, if2.out_eof);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    out_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
  endtask

  task automatic send(input logic [7:0] p, input logic sof);
    int n;
    if (bp) begin
      while ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_valid = 1'b1;
    in_pixel = p;
    in_sof   = sof;
    n = 0;
    #1;
    while (!if1.in_ready && n < 1000) begin
      tick();
      #1;
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: waited %0d cycles, expected acceptance", n);
    end
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int npix);
    for (int i = 0; i < npix; i++) send(8'(img[i]), i == 0);
  endtask

  task automatic load_model(input int npix);
    push_model(1, 1, dither_en, npix);
    push_model(2, 2, dither_en, npix);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    in_valid = 1'b0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    check({name, "_pending_outputs"}, q1.size() + q2.size(), 0);
    tick();
    tick();
  endtask

  task automatic check_frame_done(input string name);
    check({name, "_frame_done1"}, fd_cnt1, 1);
    check({name, "_frame_done2"}, fd_cnt2, 1);
    fd_cnt1 = 0;
    fd_cnt2 = 0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("idle_busy", int'({busy1, busy2}), 0);

    // All white: pixel without sof in IDLE is dropped, then a full frame.
    dither_en = 1'b1;
    send(8'h33, 1'b0);
    check("drop_idle_busy", int'(busy1), 0);
    for (int i = 0; i < 256; i++) img[i] = 255;
    load_model(256);
    check("pin_ff_pix", int'(q1[0].pix), 255);
    check("pin_ff_code", int'(q1[255].code), 1);
    send_frame(256);
    wait_drain("white");
    check_frame_done("white");

    // Uniform mid-grey with diffusion.
    for (int i = 0; i < 256; i++) img[i] = 128;
    load_model(256);
    check("pin_grey_00", int'(q1[0].pix), 255);
    check("pin_grey_01", int'(q1[1].pix), 0);
    check("pin_grey_01_code", int'(q1[1].code), 0);
    send_frame(256);
    wait_drain("grey");
    check_frame_done("grey");

    // Ramp with diffusion off: plain nearest-level quantize.
    dither_en = 1'b0;
    for (int i = 0; i < 256; i++) img[i] = i;
    load_model(256);
    check("pin_ramp_q2_80", int'(q2[128].pix), 8'hAA);
    check("pin_ramp_q2_80_code", int'(q2[128].code), 2);
    check("pin_ramp_q2_42", int'(q2[42].pix), 8'h00);
    check("pin_ramp_q2_43", int'(q2[43].pix), 8'h55);
    check("pin_ramp_q1_7f", int'(q1[127].pix), 8'h00);
    check("pin_ramp_q1_80", int'(q1[128].pix), 8'hFF);
    send_frame(256);
    wait_drain("ramp");
    check_frame_done("ramp");

    // Random image under random backpressure and input gaps.
    dither_en = 1'b1;
    bp = 1'b1;
    for (int i = 0; i < 256; i++) img[i] = int'($urandom_range(0, 255));
    load_model(256);
    send_frame(256);
    wait_drain("backpressure");
    bp = 1'b0;
    tick();
    check_frame_done("backpressure");

    // sof arriving at (3,5) restarts the frame.
    check("pre_sof_err", se_cnt1 + se_cnt2, 0);
    for (int i = 0; i < 256; i++) img[i] = int'($urandom_range(0, 255));
    load_model(53);
    send_frame(53);
    check("midframe_busy", int'({busy1, busy2}), 3);
    for (int i = 0; i < 256; i++) img[i] = int'($urandom_range(0, 255));
    load_model(256);
    send_frame(256);
    wait_drain("sof_restart");
    check("sof_err_pulses1", se_cnt1, 1);
    check("sof_err_pulses2", se_cnt2, 1);
    check_frame_done("sof_restart");

    // Reset in the middle of row 2, then a clean frame.
    for (int i = 0; i < 256; i++) img[i] = int'($urandom_range(0, 255));
    load_model(39);
    send_frame(39);
    wait_drain("pre_reset");
    check("pre_reset_busy", int'({busy1, busy2}), 3);
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_busy", int'({busy1, busy2}), 0);
    fd_cnt1 = 0;
    fd_cnt2 = 0;
    for (int i = 0; i < 256; i++) img[i] = int'($urandom_range(0, 255));
    load_model(256);
    send_frame(256);
    wait_drain("post_reset");
    check_frame_done("post_reset");
    check("final_sof_err1", se_cnt1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
